// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU issue/writeback sequencer.
package alu_pkg;

   localparam int DATA_W = 16;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_MUL   = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_LOADI = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } issue_state_e;

   function automatic logic is_alu_op(input logic [2:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // MUL and DIV return a second word that lands in the next register.
   function automatic logic writes_pair(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/regfile_2r1w_pair.sv
// Register file: two operand read ports, one debug read port, and a write port
// that can optionally write a second word to the next register (mod N).
module regfile_2r1w_pair #(
   parameter  int W  = 16,
   parameter  int N  = 4,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra_addr,
   output logic [W-1:0]  ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  rb_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [W-1:0]  dbg_data,
   input  logic          we,
   input  logic          we_pair,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data_low,
   input  logic [W-1:0]  wr_data_high
);

   logic [N-1:0][W-1:0] mem_r;
   logic [AW-1:0]       pair_addr_s;

   // Index arithmetic wraps naturally because N is a power of two.
   assign pair_addr_s = wr_addr + AW'(1);

   assign ra_data  = mem_r[ra_addr];
   assign rb_data  = mem_r[rb_addr];
   assign dbg_data = mem_r[dbg_addr];

   // Register storage with low-word and optional high-word write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_r <= '0;
      end else if (we) begin
         mem_r[wr_addr] <= wr_data_low;
         if (we_pair) begin
            mem_r[pair_addr_s] <= wr_data_high;
         end
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the ALU: accepts decoded instructions,
// starts the ALU, absorbs its latency and writes results back to the register file.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter  int NREG    = 4,
   parameter  int TIMEOUT = 64,
   localparam int AW      = $clog2(NREG),
   localparam int CW      = $clog2(TIMEOUT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [AW-1:0]     instr_rd,
   input  logic [AW-1:0]     instr_rs1,
   input  logic [AW-1:0]     instr_rs2,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   output logic              alu_start,
   input  logic [DATA_W-1:0] alu_result_low,
   input  logic [DATA_W-1:0] alu_result_high,
   input  logic              alu_done,
   output logic              wb_valid,
   output logic              err,
   output logic [15:0]       retired,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   issue_state_e      state_r;
   logic [AW-1:0]     rd_r;
   logic [CW-1:0]     cnt_r;
   logic              accept_s;
   logic [DATA_W-1:0] rs1_data_s;
   logic [DATA_W-1:0] rs2_data_s;
   logic              we_s;
   logic              we_pair_s;
   logic [AW-1:0]     wr_addr_s;
   logic [DATA_W-1:0] wr_low_s;

   assign instr_ready = (state_r == ST_IDLE);
   assign accept_s    = instr_valid & instr_ready;

   regfile_2r1w_pair #(.W(DATA_W), .N(NREG)) u_rf (
      .clk          (clk),
      .reset        (reset),
      .ra_addr      (instr_rs1),
      .ra_data      (rs1_data_s),
      .rb_addr      (instr_rs2),
      .rb_data      (rs2_data_s),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .we           (we_s),
      .we_pair      (we_pair_s),
      .wr_addr      (wr_addr_s),
      .wr_data_low  (wr_low_s),
      .wr_data_high (alu_result_high)
   );

   // Write-port steering: LOADI writes at accept, ALU ops write when done arrives in WAIT.
   always_comb begin
      we_s      = 1'b0;
      we_pair_s = 1'b0;
      wr_addr_s = rd_r;
      wr_low_s  = alu_result_low;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && (instr_op == OP_LOADI)) begin
               we_s      = 1'b1;
               wr_addr_s = instr_rd;
               wr_low_s  = instr_imm;
            end else begin
               we_s = 1'b0;
            end
         end
         ST_WAIT: begin
            if (alu_done) begin
               we_s      = 1'b1;
               we_pair_s = writes_pair(alu_opcode);
            end else begin
               we_s = 1'b0;
            end
         end
         default: begin
            we_s = 1'b0;
         end
      endcase
   end

   // Sequencer; DRAIN waits for done to fall so a held done is never taken twice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= OP_ADD;
         alu_start  <= 1'b0;
         wb_valid   <= 1'b0;
         err        <= 1'b0;
         retired    <= 16'd0;
         rd_r       <= '0;
         cnt_r      <= '0;
      end else begin
         alu_start <= 1'b0;
         wb_valid  <= 1'b0;
         err       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (is_alu_op(instr_op)) begin
                     alu_a      <= rs1_data_s;
                     alu_b      <= rs2_data_s;
                     alu_opcode <= instr_op;
                     rd_r       <= instr_rd;
                     alu_start  <= 1'b1;
                     cnt_r      <= '0;
                     state_r    <= ST_WAIT;
                  end else if (instr_op == OP_LOADI) begin
                     retired <= retired + 16'd1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (alu_done) begin
                  wb_valid <= 1'b1;
                  retired  <= retired + 16'd1;
                  state_r  <= ST_DRAIN;
               end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                  err     <= 1'b1;
                  state_r <= ST_DRAIN;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (!alu_done) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stub and a reference model.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int NREG    = 4;
   localparam int AW      = 2;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              instr_valid = 1'b0;
   logic              instr_ready;
   logic [2:0]        instr_op = 3'b000;
   logic [AW-1:0]     instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
   logic [DATA_W-1:0] instr_imm = '0;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [2:0]        alu_opcode;
   logic              alu_start;
   logic [DATA_W-1:0] alu_result_low = '0, alu_result_high = '0;
   logic              alu_done = 1'b0;
   logic              wb_valid, err;
   logic [15:0]       retired;
   logic [AW-1:0]     dbg_addr = '0;
   logic [DATA_W-1:0] dbg_data;

   alu_issue_ctrl #(.NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_start(alu_start), .alu_result_low(alu_result_low), .alu_result_high(alu_result_high),
      .alu_done(alu_done), .wb_valid(wb_valid), .err(err), .retired(retired),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU behaviour: signed MUL/DIV, quotient in low and remainder in high, x/0 -> 0/0.
   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      logic signed [15:0] sa, sb, q, r;
      sa = a;
      sb = b;
      case (op)
         OP_ADD: return {16'h0000, 16'(a + b)};
         OP_SUB: return {16'h0000, 16'(a - b)};
         OP_MUL: begin p = 32'(sa) * 32'(sb); return p; end
         OP_DIV: begin
            if (b == 16'h0000) return 32'h0;
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         default: return 32'h0;
      endcase
   endfunction

   // Stub ALU: ADD/SUB done after one cycle for one cycle; MUL/DIV after 2-6 cycles, done held two cycles.
   logic        stub_busy = 1'b0;
   logic        stub_hang = 1'b0;
   int          stub_cnt = 0, stub_hold = 0, stub_hold_len = 0, stub_lat_force = 0;
   logic [31:0] stub_res = 32'h0;
   always @(posedge clk) begin
      if (stub_hold != 0) begin
         stub_hold <= stub_hold - 1;
         if (stub_hold == 1) alu_done <= 1'b0;
      end else if (stub_busy) begin
         if (stub_cnt <= 1) begin
            alu_result_low  <= stub_res[15:0];
            alu_result_high <= stub_res[31:16];
            alu_done        <= 1'b1;
            stub_hold       <= stub_hold_len;
            stub_busy       <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end else if (alu_start === 1'b1 && !stub_hang) begin
         stub_res  <= alu_ref(alu_opcode, alu_a, alu_b);
         stub_busy <= 1'b1;
         if (alu_opcode == OP_MUL || alu_opcode == OP_DIV) begin
            stub_hold_len <= 2;
            if (alu_opcode == OP_DIV && alu_b == 16'h0000) stub_cnt <= 1;
            else if (stub_lat_force != 0)                  stub_cnt <= stub_lat_force;
            else                                           stub_cnt <= int'($urandom_range(2, 6));
         end else begin
            stub_hold_len <= 1;
            stub_cnt      <= 1;
         end
      end
   end

   typedef struct {
      bit                         is_err;
      logic [15:0]                ret;
      logic [NREG-1:0][DATA_W-1:0] regs;
   } ev_t;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
   } iss_t;

   ev_t  exp_q[$];
   iss_t iss_q[$];
   logic [NREG-1:0][DATA_W-1:0] m = '0;
   logic [15:0] m_ret = 16'd0;
   int n_chk = 0, n_fail = 0;
   int wb_seen = 0, last_pulse_edge = 0, last_acc_edge = 0;
   int snap_req = 0, snap_served = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_regs(input logic [NREG-1:0][DATA_W-1:0] regs);
      for (int i = 0; i < NREG; i++) begin
         dbg_addr = AW'(i);
         #1;
         check($sformatf("reg%0d", i), dbg_data, regs[i]);
      end
   endtask

   // Monitor: pops expectations when the DUT presents alu_start, wb_valid or err.
   task automatic monitor();
      ev_t  e;
      iss_t s;
      forever begin
         @(negedge clk);
         if (alu_start === 1'b1) begin
            if (iss_q.size() == 0) check("unexpected_start", alu_start, 1'b0);
            else begin
               s = iss_q.pop_front();
               check("alu_a", alu_a, s.a);
               check("alu_b", alu_b, s.b);
               check("alu_opcode", alu_opcode, s.op);
            end
         end
         if (wb_valid === 1'b1 || err === 1'b1) begin
            wb_seen++;
            last_pulse_edge = cyc;
            if (exp_q.size() == 0) check("unexpected_pulse", {wb_valid, err}, 2'b00);
            else begin
               e = exp_q.pop_front();
               check("err", err, e.is_err);
               check("wb_valid", wb_valid, !e.is_err);
               check("retired", retired, e.ret);
               compare_regs(e.regs);
            end
         end else if (snap_served != snap_req) begin
            compare_regs(m);
            snap_served++;
         end
      end
   endtask

   task automatic snapshot();
      int n = 0;
      snap_req++;
      while (snap_served != snap_req && n < 20) begin @(negedge clk); n++; end
      if (snap_served != snap_req) check("snapshot_timeout", snap_served, snap_req);
   endtask

   task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2, input logic [15:0] imm);
      int n = 0;
      ev_t e;
      iss_t s;
      logic [31:0] r;
      while (instr_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      if (instr_ready !== 1'b1) begin check("ready_timeout", instr_ready, 1'b1); return; end
      instr_valid = 1'b1; instr_op = op; instr_imm = imm;
      instr_rd = AW'(rd); instr_rs1 = AW'(rs1); instr_rs2 = AW'(rs2);
      last_acc_edge = cyc + 1;
      @(posedge clk);
      if (op <= OP_DIV) begin
         s.a = m[rs1]; s.b = m[rs2]; s.op = op;
         iss_q.push_back(s);
         if (stub_hang) e.is_err = 1'b1;
         else begin
            r = alu_ref(op, s.a, s.b);
            m[rd] = r[15:0];
            if (op == OP_MUL || op == OP_DIV) m[(rd + 1) % NREG] = r[31:16];
            m_ret++;
            e.is_err = 1'b0;
         end
         e.ret = m_ret; e.regs = m;
         exp_q.push_back(e);
      end else if (op == OP_LOADI) begin
         m[rd] = imm;
         m_ret++;
      end else begin
         e.is_err = 1'b1; e.ret = m_ret; e.regs = m;
         exp_q.push_back(e);
      end
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_pulse(input int seen);
      int n = 0;
      while (wb_seen == seen && n < 200) begin @(negedge clk); n++; end
      if (wb_seen == seen) check("pulse_timeout", wb_seen, seen + 1);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || instr_ready !== 1'b1 || alu_done !== 1'b0 || stub_busy) && n < max) begin
         @(negedge clk); n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int acc, seen, sel;
      logic [2:0] op;
      logic [15:0] imm;
      fork monitor(); join_none
      #3 reset = 1'b0;
      #1;
      check("rst_alu_a", alu_a, 16'h0);
      check("rst_alu_b", alu_b, 16'h0);
      check("rst_opcode", alu_opcode, 3'b000);
      check("rst_start", alu_start, 1'b0);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_retired", retired, 16'h0);
      check("rst_ready", instr_ready, 1'b1);
      @(negedge clk);
      snapshot();
      reset = 1'b1;
      @(negedge clk);

      // ADD with latency check
      issue(OP_LOADI, 1, 0, 0, 16'd5);
      issue(OP_LOADI, 2, 0, 0, 16'd7);
      seen = wb_seen;
      issue(OP_ADD, 0, 1, 2, 16'h0);
      acc = last_acc_edge;
      wait_pulse(seen);
      check("add_latency", last_pulse_edge - acc, 3);
      drain(100);

      // Signed MUL spanning two registers, done held two cycles
      issue(OP_LOADI, 1, 0, 0, 16'hFFFD);
      issue(OP_LOADI, 2, 0, 0, 16'd1000);
      issue(OP_MUL, 0, 1, 2, 16'h0);
      drain(100);

      // DIV with rd wrap and gap to next accept
      issue(OP_LOADI, 1, 0, 0, 16'd100);
      issue(OP_LOADI, 2, 0, 0, 16'd7);
      seen = wb_seen;
      issue(OP_DIV, 3, 1, 2, 16'h0);
      wait_pulse(seen);
      acc = last_pulse_edge;
      issue(OP_LOADI, 2, 0, 0, 16'd0);
      check("drain_gap_ge3", (last_acc_edge - acc) >= 3, 1'b1);

      // Divide by zero, then illegal opcode
      issue(OP_DIV, 1, 1, 2, 16'h0);
      drain(100);
      issue(3'b111, 0, 1, 2, 16'h0);
      check("ready_after_illegal", instr_ready, 1'b1);
      drain(100);

      // ALU never answers: timeout
      stub_hang = 1'b1;
      seen = wb_seen;
      issue(OP_ADD, 0, 1, 3, 16'h0);
      acc = last_acc_edge;
      wait_pulse(seen);
      check("timeout_cycles", last_pulse_edge - acc, TIMEOUT);
      drain(200);
      stub_hang = 1'b0;

      // Asynchronous reset in the middle of a long MUL
      issue(OP_LOADI, 1, 0, 0, 16'd3);
      issue(OP_LOADI, 2, 0, 0, 16'd4);
      stub_lat_force = 12;
      issue(OP_MUL, 0, 1, 2, 16'h0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      exp_q.delete();
      m = '0;
      m_ret = 16'd0;
      #1;
      check("mid_rst_alu_a", alu_a, 16'h0);
      check("mid_rst_alu_b", alu_b, 16'h0);
      check("mid_rst_opcode", alu_opcode, 3'b000);
      check("mid_rst_retired", retired, 16'h0);
      check("mid_rst_ready", instr_ready, 1'b1);
      @(negedge clk);
      snapshot();
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_retired", retired, 16'h0);
      snapshot();
      stub_lat_force = 0;
      drain(100);

      // Randomized mix
      for (int k = 0; k < 250; k++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 40)      op = OP_LOADI;
         else if (sel < 52) op = OP_ADD;
         else if (sel < 64) op = OP_SUB;
         else if (sel < 78) op = OP_MUL;
         else if (sel < 94) op = OP_DIV;
         else               op = 3'(5 + $urandom_range(0, 2));
         imm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), imm);
      end
      drain(500);
      snapshot();
      check("final_retired", retired, m_ret);
      check("issue_q_empty", iss_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
